digest_display_scanner: RTL and testbench

- Producer side of the per-digit hex segment encoder. Latches the 256-bit SHA-256 digest when the hash core finishes, and time-multiplexes it onto an 8-digit common-anode display.
- Each clock slot it presents one 4-bit nibble on value, the display-enable flag on rounds_done, and one active-low anode enable on an.
- The 64 digest nibbles are shown as 8 pages of 8 digits. page_next steps through the pages.

---
 rtl/digest_display_scanner.sv | 123 ++++++++++++
 tb/tb_digest_display_scanner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/digest_display_scanner.sv
// Latches a 256-bit SHA-256 digest and time-multiplexes it, 8 nibbles per page,
// onto an 8-digit common-anode display with a blanking gap at the start of each slot.
module digest_display_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] digest_in,
  input  logic         digest_valid,
  input  logic         digest_clear,
  input  logic         page_next,
  output logic [3:0]   value,
  output logic         rounds_done,
  output logic [7:0]   an,
  output logic [2:0]   page
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  logic [255:0]   digest_reg, digest_next;
  logic [2:0]     page_idx_reg, page_idx_next;
  logic [CNT_W-1:0] div_cnt_reg;
  logic [2:0]     digit_idx_reg;
  logic [3:0]     value_reg;
  logic [7:0]     an_reg;
  logic           rounds_done_reg;

  logic [31:0]    word_arr [8];
  logic [31:0]    cur_word;
  logic [3:0]     nib_arr [8];
  logic [3:0]     cur_nib;
  logic [7:0]     an_dec;

  // Page 0 is H0, the most significant word of the digest.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      assign word_arr[gi] = digest_reg[255 - 32*gi -: 32];
    end
  endgenerate

  assign cur_word = word_arr[page_idx_reg];

  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign nib_arr[gi] = cur_word[4*gi +: 4];
      assign an_dec[gi]  = ~(digit_idx_reg == 3'(gi));
    end
  endgenerate

  assign cur_nib = nib_arr[digit_idx_reg];

  // Capture beats clear, and either one swallows a coincident page step.
  always_comb begin
    state_next    = state_reg;
    digest_next   = digest_reg;
    page_idx_next = page_idx_reg;
    case (state_reg)
      EMPTY: begin
        if (digest_valid) begin
          state_next    = HOLD;
          digest_next   = digest_in;
          page_idx_next = 3'd0;
        end
      end
      HOLD: begin
        if (digest_valid) begin
          digest_next   = digest_in;
          page_idx_next = 3'd0;
        end else if (digest_clear) begin
          state_next    = EMPTY;
          digest_next   = '0;
          page_idx_next = 3'd0;
        end else if (page_next) begin
          page_idx_next = page_idx_reg + 3'd1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= EMPTY;
      digest_reg      <= '0;
      page_idx_reg    <= 3'd0;
      div_cnt_reg     <= '0;
      digit_idx_reg   <= 3'd0;
      value_reg       <= 4'h0;
      an_reg          <= 8'hFF;
      rounds_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      digest_reg   <= digest_next;
      page_idx_reg <= page_idx_next;
      // Scan timing is free-running and independent of capture/clear/paging.
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_reg   <= '0;
        digit_idx_reg <= digit_idx_reg + 3'd1;
      end else begin
        div_cnt_reg <= div_cnt_reg + CNT_W'(1);
      end
      value_reg       <= cur_nib;
      an_reg          <= (div_cnt_reg < BLANK_END) ? 8'hFF : an_dec;
      rounds_done_reg <= (state_reg == HOLD);
    end
  end

  assign value       = value_reg;
  assign an          = an_reg;
  assign rounds_done = rounds_done_reg;
  assign page        = page_idx_reg;

endmodule

// File: tb/tb_digest_display_scanner.sv
// Bench for digest_display_scanner: cycle model derived from elapsed time plus
// directed scenarios with hand-computed expectations.
module tb_digest_display_scanner;

  localparam int RD = 4;
  localparam int BC = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [255:0] digest_in = '0;
  logic         digest_valid = 1'b0;
  logic         digest_clear = 1'b0;
  logic         page_next = 1'b0;
  logic [3:0]   value;
  logic         rounds_done;
  logic [7:0]   an;
  logic [2:0]   page;

  int total = 0;
  int bad = 0;

  localparam logic [255:0] D1 = 256'h01234567_89ABCDEF_FEDCBA98_76543210_DEADBEEF_CAFEBABE_13579BDF_2468ACE0;
  localparam logic [255:0] D2 = 256'hFEEDF00D_11111111_22222222_33333333_44444444_55555555_66666666_77777777;
  localparam logic [255:0] D3 = 256'h0BADC0DE_00000000_00000000_00000000_00000000_00000000_00000000_00000000;

  digest_display_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .digest_in(digest_in), .digest_valid(digest_valid),
    .digest_clear(digest_clear), .page_next(page_next), .value(value),
    .rounds_done(rounds_done), .an(an), .page(page)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib(input logic [255:0] dg, input int pg, input int d);
    logic [255:0] s;
    s = dg >> (32*(7 - pg) + 4*d);
    return s[3:0];
  endfunction

  // Reference model: scan position follows from cycles elapsed since reset.
  int           m_t;
  logic         m_held;
  int           m_page;
  logic [255:0] m_dig;
  initial begin
    int dv, d;
    logic [7:0] e_an;
    logic [3:0] e_val;
    logic       e_rd;
    m_t = 0; m_held = 1'b0; m_page = 0; m_dig = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_t = 0; m_held = 1'b0; m_page = 0; m_dig = '0;
      end else begin
        dv    = m_t % RD;
        d     = (m_t / RD) % 8;
        e_an  = (dv < BC) ? 8'hFF : ~(8'h01 << d);
        e_val = nib(m_dig, m_page, d);
        e_rd  = m_held;
        m_t++;
        if (digest_valid) begin
          m_dig = digest_in; m_page = 0; m_held = 1'b1;
        end else if (digest_clear) begin
          if (m_held) begin m_dig = '0; m_page = 0; m_held = 1'b0; end
        end else if (page_next && m_held) begin
          m_page = (m_page + 1) % 8;
        end
        #1;
        check("model_an", {24'd0, an}, {24'd0, e_an});
        check("model_value", {28'd0, value}, {28'd0, e_val});
        check("model_rounds_done", {31'd0, rounds_done}, {31'd0, e_rd});
        check("model_page", {29'd0, page}, m_page);
        check("one_hot_an", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
      end
    end
  end

  task automatic wait_an(input logic [7:0] target, input string nm);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (an === target) return;
    end
    check({nm, "_timeout"}, {24'd0, an}, {24'd0, target});
  endtask

  task automatic pulse(input logic v, input logic c, input logic p, input logic [255:0] dg);
    @(negedge clk);
    digest_in = dg; digest_valid = v; digest_clear = c; page_next = p;
    @(negedge clk);
    digest_valid = 1'b0; digest_clear = 1'b0; page_next = 1'b0;
  endtask

  logic [3:0] low_nib [8];

  initial begin
    low_nib = '{4'h7, 4'hF, 4'h8, 4'h0, 4'hF, 4'hE, 4'hF, 4'h0};

    // 1: reset, then idle scan
    #2 rst = 1'b1;
    #1;
    check("reset_an", {24'd0, an}, 32'hFF);
    check("reset_rounds_done", {31'd0, rounds_done}, 32'd0);
    check("reset_value", {28'd0, value}, 32'd0);
    check("reset_page", {29'd0, page}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      case (k)
        1:  check("idle_an_k1", {24'd0, an}, 32'hFF);
        2:  check("idle_an_k2", {24'd0, an}, 32'hFE);
        5:  check("idle_an_k5", {24'd0, an}, 32'hFF);
        6:  check("idle_an_k6", {24'd0, an}, 32'hFD);
        30: check("idle_an_k30", {24'd0, an}, 32'h7F);
        34: check("idle_an_wrap", {24'd0, an}, 32'hFE);
        40: check("idle_rounds_done", {31'd0, rounds_done}, 32'd0);
        default: ;
      endcase
    end

    // 2: capture
    pulse(1'b1, 1'b0, 1'b0, D1);
    @(posedge clk); #1;
    check("cap_rounds_done", {31'd0, rounds_done}, 32'd1);
    check("cap_page", {29'd0, page}, 32'd0);
    wait_an(8'hFE, "cap_d0");
    check("cap_digit0", {28'd0, value}, 32'h7);
    wait_an(8'h7F, "cap_d7");
    check("cap_digit7", {28'd0, value}, 32'h0);

    // 3: paging through all eight words and wrapping
    for (int k = 1; k <= 8; k++) begin
      pulse(1'b0, 1'b0, 1'b1, D1);
      check("page_idx", {29'd0, page}, k % 8);
      wait_an(8'hFE, "page_d0");
      check("page_low_nib", {28'd0, value}, {28'd0, low_nib[k % 8]});
    end

    // 4: capture overrides page step and clear
    repeat (5) pulse(1'b0, 1'b0, 1'b1, D1);
    check("at_page5", {29'd0, page}, 32'd5);
    pulse(1'b1, 1'b0, 1'b1, D2);
    check("cap_page_next_page", {29'd0, page}, 32'd0);
    wait_an(8'hFE, "d2_d0");
    check("d2_low_nib", {28'd0, value}, 32'hD);
    pulse(1'b1, 1'b1, 1'b0, D3);
    @(posedge clk); #1;
    check("cap_clear_rounds_done", {31'd0, rounds_done}, 32'd1);
    wait_an(8'hFE, "d3_d0");
    check("d3_low_nib", {28'd0, value}, 32'hE);

    // 5: clear in HOLD, then page_next ignored in EMPTY
    pulse(1'b0, 1'b1, 1'b0, D1);
    @(posedge clk); #1;
    check("clr_rounds_done", {31'd0, rounds_done}, 32'd0);
    check("clr_page", {29'd0, page}, 32'd0);
    check("clr_value", {28'd0, value}, 32'd0);
    pulse(1'b0, 1'b0, 1'b1, D1);
    check("empty_page_next", {29'd0, page}, 32'd0);
    repeat (10) @(posedge clk);

    // 6: asynchronous reset mid-slot
    pulse(1'b1, 1'b0, 1'b0, D1);
    wait_an(8'hEF, "pre_rst");
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", {24'd0, an}, 32'hFF);
    check("async_rst_rounds_done", {31'd0, rounds_done}, 32'd0);
    check("async_rst_page", {29'd0, page}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_an_k1", {24'd0, an}, 32'hFF);
    @(posedge clk); #1;
    check("post_rst_an_k2", {24'd0, an}, 32'hFE);
    check("post_rst_rounds_done", {31'd0, rounds_done}, 32'd0);
    repeat (20) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
